// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: two valid/ready producers share one FIFO write port.
// A grant is held for at most BURST_MAX accepted words, then moves to the other
// producer if it is waiting. On a tie from idle, the producer that was not served
// last wins. After reset, s0 wins the first tie. Each producer also has a
// saturating count of the words accepted from it.
module fifo_wr_arbiter #(
  parameter int unsigned DW        = 4,
  parameter int unsigned BURST_MAX = 4,
  parameter int unsigned CW        = 8
) (
  input  logic          clk,
  input  logic          rst_a,
  input  logic          s0_valid,
  input  logic [DW-1:0] s0_data,
  output logic          s0_ready,
  input  logic          s1_valid,
  input  logic [DW-1:0] s1_data,
  output logic          s1_ready,
  input  logic          fifo_full,
  output logic          fifo_wr_en,
  output logic [DW-1:0] fifo_data_in,
  output logic [1:0]    owner,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1
);

  // Burst counter only needs to reach BURST_MAX-1.
  localparam int unsigned BW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [BW-1:0] BurstLast = BW'(BURST_MAX - 1);

  // The state encoding doubles as the one-hot owner value.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StOwn0 = 2'b01,
    StOwn1 = 2'b10
  } state_e;

  state_e        state_q;
  logic [BW-1:0] burst_q;
  logic          last_q;   // 0: s0 was served last, 1: s1 was served last
  logic [DW-1:0] data_q;   // last word written, held on fifo_data_in between writes
  logic [CW-1:0] cnt0_q;
  logic [CW-1:0] cnt1_q;

  logic   own0;
  logic   own1;
  logic   xfer0;
  logic   xfer1;
  logic   xfer;
  logic   own_valid;
  logic   other_valid;
  logic   burst_end;
  state_e other_st;

  // Handshake and FIFO write path, combinational from the current owner.
  always_comb begin
    own0         = (state_q == StOwn0);
    own1         = (state_q == StOwn1);
    s0_ready     = own0 & ~fifo_full;
    s1_ready     = own1 & ~fifo_full;
    xfer0        = s0_valid & s0_ready;
    xfer1        = s1_valid & s1_ready;
    xfer         = xfer0 | xfer1;
    fifo_wr_en   = xfer;
    fifo_data_in = data_q;
    if (xfer0) begin
      fifo_data_in = s0_data;
    end else if (xfer1) begin
      fifo_data_in = s1_data;
    end
    own_valid   = own0 ? s0_valid : s1_valid;
    other_valid = own0 ? s1_valid : s0_valid;
    other_st    = own0 ? StOwn1 : StOwn0;
    burst_end   = (burst_q == BurstLast);
  end

  // Arbitration state, burst tracking, held write data and acceptance counters.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      state_q <= StIdle;
      burst_q <= '0;
      last_q  <= 1'b1;
      data_q  <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      if (xfer0 && !(&cnt0_q)) begin
        cnt0_q <= cnt0_q + 1'b1;
      end
      if (xfer1 && !(&cnt1_q)) begin
        cnt1_q <= cnt1_q + 1'b1;
      end
      if (xfer) begin
        data_q <= fifo_data_in;
      end

      unique case (state_q)
        StIdle: begin
          burst_q <= '0;
          if (s0_valid && s1_valid) begin
            state_q <= last_q ? StOwn0 : StOwn1;
          end else if (s0_valid) begin
            state_q <= StOwn0;
          end else if (s1_valid) begin
            state_q <= StOwn1;
          end
        end
        StOwn0, StOwn1: begin
          if (xfer) begin
            if (burst_end) begin
              // Burst exhausted: hand over without a bubble if the other side waits.
              burst_q <= '0;
              last_q  <= own1;
              if (other_valid) begin
                state_q <= other_st;
              end else if (!own_valid) begin
                state_q <= StIdle;
              end
            end else begin
              burst_q <= burst_q + 1'b1;
            end
          end else if (!own_valid) begin
            // Owner went quiet: release the grant.
            burst_q <= '0;
            last_q  <= own1;
            state_q <= other_valid ? other_st : StIdle;
          end
          // Owner valid but FIFO full: hold grant, nothing counted.
        end
        default: begin
          state_q <= StIdle;
          burst_q <= '0;
        end
      endcase
    end
  end

  assign owner = state_q;
  assign cnt0  = cnt0_q;
  assign cnt1  = cnt1_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: a grant-level reference model is checked every cycle,
// and literal expectations from the directed scenarios pin that model.
module tb_fifo_wr_arbiter;

  localparam int DW        = 4;
  localparam int BURST_MAX = 4;
  localparam int CW        = 4;  // small, so saturation is reachable
  localparam int CMAX      = (1 << CW) - 1;

  logic          clk;
  logic          rst_a;
  logic          s0_valid;
  logic [DW-1:0] s0_data;
  logic          s0_ready;
  logic          s1_valid;
  logic [DW-1:0] s1_data;
  logic          s1_ready;
  logic          fifo_full;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_data_in;
  logic [1:0]    owner;
  logic [CW-1:0] cnt0;
  logic [CW-1:0] cnt1;

  fifo_wr_arbiter #(
    .DW       (DW),
    .BURST_MAX(BURST_MAX),
    .CW       (CW)
  ) dut (
    .clk         (clk),
    .rst_a       (rst_a),
    .s0_valid    (s0_valid),
    .s0_data     (s0_data),
    .s0_ready    (s0_ready),
    .s1_valid    (s1_valid),
    .s1_data     (s1_data),
    .s1_ready    (s1_ready),
    .fifo_full   (fifo_full),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_data_in(fifo_data_in),
    .owner       (owner),
    .cnt0        (cnt0),
    .cnt1        (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: who holds the grant (-1 none, else producer index),
  // words accepted in this grant, who was served last, counters, held word.
  int m_who;
  int m_words;
  int m_last;
  int m_cnt[2];
  int m_held;
  bit m_x[2];

  // Stimulus bookkeeping.
  int q0[$];
  int q1[$];
  bit full_q[$];
  int st0;
  int st1;
  int cyc;
  int wlog[$];
  int wcyc[$];
  int exp_d[$];
  int exp_c[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_who   = -1;
    m_words = 0;
    m_last  = 1;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    m_held  = 0;
    m_x[0]  = 1'b0;
    m_x[1]  = 1'b0;
  endfunction

  // Check every DUT output against what the grant rules imply for this cycle.
  task automatic check_cycle();
    bit v[2];
    int d[2];
    int rdy[2];
    int wr;
    int data;
    v[0] = s0_valid;
    v[1] = s1_valid;
    d[0] = int'(s0_data);
    d[1] = int'(s1_data);
    for (int p = 0; p < 2; p++) begin
      rdy[p] = (m_who == p && !fifo_full) ? 1 : 0;
      m_x[p] = (rdy[p] == 1) && v[p];
    end
    wr   = (m_x[0] || m_x[1]) ? 1 : 0;
    data = m_x[0] ? d[0] : (m_x[1] ? d[1] : m_held);
    chk("s0_ready", int'(s0_ready), rdy[0]);
    chk("s1_ready", int'(s1_ready), rdy[1]);
    chk("fifo_wr_en", int'(fifo_wr_en), wr);
    chk("fifo_data_in", int'(fifo_data_in), data);
    chk("owner", int'(owner), (m_who < 0) ? 0 : (1 << m_who));
    chk("cnt0", int'(cnt0), m_cnt[0]);
    chk("cnt1", int'(cnt1), m_cnt[1]);
  endtask

  // Advance the model across one clock edge using the inputs of the cycle just ended.
  task automatic model_edge();
    bit v[2];
    int d[2];
    v[0] = s0_valid;
    v[1] = s1_valid;
    d[0] = int'(s0_data);
    d[1] = int'(s1_data);
    if (!rst_a) begin
      model_reset();
    end else if (m_who < 0) begin
      if (v[0] && v[1]) m_who = 1 - m_last;
      else if (v[0]) m_who = 0;
      else if (v[1]) m_who = 1;
      m_words = 0;
    end else begin
      int p;
      int o;
      p = m_who;
      o = 1 - p;
      if (m_x[p]) begin
        if (m_cnt[p] < CMAX) m_cnt[p] = m_cnt[p] + 1;
        m_held  = d[p];
        m_words = m_words + 1;
        if (m_words == BURST_MAX) begin
          m_words = 0;
          m_last  = p;
          if (v[o]) m_who = o;
          else if (!v[p]) m_who = -1;
        end
      end else if (!v[p]) begin
        m_words = 0;
        m_last  = p;
        m_who   = v[o] ? o : -1;
      end
    end
  endtask

  // One cycle: compare mid-cycle, log DUT writes, cross the edge, advance model.
  task automatic tick();
    #1;
    check_cycle();
    if (fifo_wr_en) begin
      wlog.push_back(int'(fifo_data_in));
      wcyc.push_back(cyc);
    end
    @(posedge clk);
    model_edge();
    if (m_x[0] && q0.size() > 0) void'(q0.pop_front());
    if (m_x[1] && q1.size() > 0) void'(q1.pop_front());
    cyc++;
    #1;
  endtask

  task automatic drive();
    s0_valid  = (q0.size() > 0) && (cyc >= st0);
    s0_data   = (q0.size() > 0) ? DW'(q0[0]) : '0;
    s1_valid  = (q1.size() > 0) && (cyc >= st1);
    s1_data   = (q1.size() > 0) ? DW'(q1[0]) : '0;
    fifo_full = (full_q.size() > 0) ? full_q.pop_front() : 1'b0;
  endtask

  task automatic run(input int budget);
    cyc = 0;
    wlog.delete();
    wcyc.delete();
    while ((q0.size() > 0 || q1.size() > 0) && cyc < budget) begin
      drive();
      tick();
    end
    chk("run_drained", q0.size() + q1.size(), 0);
    q0.delete();
    q1.delete();
    full_q.delete();
    st0 = 0;
    st1 = 0;
    repeat (2) begin
      drive();
      tick();
    end
  endtask

  task automatic chk_log(input string name);
    chk({name, "_nwrites"}, wlog.size(), exp_d.size());
    for (int i = 0; i < exp_d.size() && i < wlog.size(); i++) begin
      chk({name, "_data"}, wlog[i], exp_d[i]);
      if (i < exp_c.size()) chk({name, "_cycle"}, wcyc[i], exp_c[i]);
    end
  endtask

  task automatic do_reset();
    rst_a = 1'b0;
    model_reset();
    q0.delete();
    q1.delete();
    full_q.delete();
    s0_valid  = 1'b0;
    s1_valid  = 1'b0;
    fifo_full = 1'b0;
    repeat (2) tick();
    rst_a = 1'b1;
  endtask

  initial begin
    st0 = 0;
    st1 = 0;
    cyc = 0;
    rst_a     = 1'b0;
    s0_valid  = 1'b1;
    s1_valid  = 1'b1;
    s0_data   = '0;
    s1_data   = '0;
    fifo_full = 1'b0;
    model_reset();
    @(posedge clk);
    #1;

    // Reset held with both producers requesting.
    repeat (3) tick();
    chk("rst_owner", int'(owner), 0);
    chk("rst_wr_en", int'(fifo_wr_en), 0);
    chk("rst_ready", int'(s0_ready) + int'(s1_ready), 0);
    chk("rst_cnt", int'(cnt0) + int'(cnt1), 0);

    // s0 alone streams 1..5 across the burst boundary without a gap.
    q0 = '{1, 2, 3, 4, 5};
    rst_a = 1'b1;
    run(20);
    exp_d = '{1, 2, 3, 4, 5};
    exp_c = '{1, 2, 3, 4, 5};
    chk_log("s0_only");
    chk("s0_only_cnt0", int'(cnt0), 5);

    // Both busy: bursts of four alternate with no bubble.
    do_reset();
    q0 = '{1, 2, 3, 4, 5, 6, 7, 8};
    q1 = '{9, 10, 11, 12, 13, 14, 15, 0};
    run(40);
    exp_d = '{1, 2, 3, 4, 9, 10, 11, 12, 5, 6, 7, 8, 13, 14, 15, 0};
    exp_c = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16};
    chk_log("rr");
    chk("rr_cnt0", int'(cnt0), 8);
    chk("rr_cnt1", int'(cnt1), 8);

    // FIFO full for three cycles inside an s1 burst: stall, no rotation.
    do_reset();
    q1 = '{1, 2, 3, 4, 5, 6};
    q0 = '{8};
    st0 = 3;
    full_q = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    run(40);
    exp_d = '{1, 2, 3, 4, 8, 5, 6};
    exp_c = '{1, 2, 6, 7, 8, 10, 11};
    chk_log("full");

    // s0 runs dry after two words: one empty cycle, then s1.
    do_reset();
    q0 = '{1, 2};
    q1 = '{9, 10};
    run(20);
    exp_d = '{1, 2, 9, 10};
    exp_c = '{1, 2, 4, 5};
    chk_log("drop");

    // Asynchronous reset in the middle of an s0 burst.
    do_reset();
    q0 = '{1, 2, 3};
    cyc = 0;
    wlog.delete();
    wcyc.delete();
    repeat (2) begin
      drive();
      tick();
    end
    drive();
    rst_a = 1'b0;
    model_reset();
    #1;
    chk("async_owner", int'(owner), 0);
    chk("async_wr_en", int'(fifo_wr_en), 0);
    chk("async_cnt0", int'(cnt0), 0);
    tick();
    chk("async_nwrites", wlog.size(), 1);
    q0.delete();
    rst_a = 1'b1;
    q0 = '{5};
    q1 = '{6};
    run(20);
    exp_d = '{5, 6};
    exp_c = '{1, 3};
    chk_log("post_rst");

    // Counter saturation.
    do_reset();
    for (int i = 0; i < 20; i++) q0.push_back(i & 15);
    run(40);
    chk("sat_cnt0", int'(cnt0), CMAX);
    chk("sat_cnt1", int'(cnt1), 0);

    // Random traffic; producers hold a word until it is accepted.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (!(s0_valid && !m_x[0])) begin
        s0_valid = ($urandom_range(0, 99) < 65);
        s0_data  = DW'($urandom());
      end
      if (!(s1_valid && !m_x[1])) begin
        s1_valid = ($urandom_range(0, 99) < 65);
        s1_data  = DW'($urandom());
      end
      fifo_full = ($urandom_range(0, 99) < 20);
      if ($urandom_range(0, 599) == 0) begin
        rst_a = 1'b0;
        model_reset();
        tick();
        rst_a = 1'b1;
      end else begin
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
